// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package stall_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  // Bit positions within stall_out, one per pipeline register.
  localparam int unsigned STALL_BIT_PC  = 0;
  localparam int unsigned STALL_BIT_IF  = 1;
  localparam int unsigned STALL_BIT_ID  = 2;
  localparam int unsigned STALL_BIT_EX  = 3;
  localparam int unsigned STALL_BIT_MEM = 4;
  localparam int unsigned STALL_BIT_WB  = 5;

  // Stall vectors: each request holds its own stage and everything upstream.
  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  localparam logic [STALL_W-1:0] STALL_IF   = (STALL_W'(1) << STALL_BIT_PC)
                                            | (STALL_W'(1) << STALL_BIT_IF);
  localparam logic [STALL_W-1:0] STALL_ID   = STALL_IF
                                            | (STALL_W'(1) << STALL_BIT_ID);
  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_ID
                                            | (STALL_W'(1) << STALL_BIT_EX)
                                            | (STALL_W'(1) << STALL_BIT_MEM);
  // WB is never held: the write-back stage always retires.
  localparam logic [STALL_W-1:0] STALL_WB_MASK = STALL_W'(1) << STALL_BIT_WB;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  // Priority-encode the stall requests: mem > id > if.
  function automatic logic [STALL_W-1:0] stall_vec(input logic mem, input logic id,
                                                   input logic ifr);
    logic [STALL_W-1:0] v;
    if (mem)      v = STALL_MEM;
    else if (id)  v = STALL_ID;
    else if (ifr) v = STALL_IF;
    else          v = STALL_NONE;
    return v & ~STALL_WB_MASK;
  endfunction

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + WIDTH'(1);
  end

  // Count register; frozen while rdy is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (rdy_i) cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller with IF redirect-discard handshake
// and saturating performance counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_mem,
  input  logic              branch_req_ex,
  input  logic [ADDR_W-1:0] branch_target_ex,
  input  logic              if_busy,
  output logic [5:0]        stall_out,
  output logic              branch_or_not,
  output logic [ADDR_W-1:0] branch_target,
  output logic              if_discard,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e state_q;
  state_e state_d;
  logic   br_acc;
  logic   stall_any;

  // Stall vector by request priority; a redirect never alters it.
  always_comb begin
    stall_out = stall_vec(stallreq_mem, stallreq_id, stallreq_if);
  end

  // A branch is taken only when EX is not held by a MEM stall.
  always_comb begin
    br_acc        = branch_req_ex && !stallreq_mem;
    branch_or_not = br_acc;
    branch_target = br_acc ? branch_target_ex : '0;
  end

  assign stall_any = |stall_out;

  // FSM state register; holds while rdy is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state_q <= ST_RUN;
    else if (rdy_in) state_q <= state_d;
  end

  // FSM next state: wait out a fetch that was in flight at redirect time.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (br_acc && if_busy) state_d = ST_DISCARD;
      ST_DISCARD: if (!if_busy)          state_d = ST_RUN;
      default:                           state_d = ST_RUN;
    endcase
  end

  // FSM output: discard is raised already in the acceptance cycle.
  always_comb begin
    if_discard = (state_q == ST_DISCARD) || (br_acc && if_busy);
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .rdy_i (rdy_in),
    .inc_i (stall_any),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .rdy_i (rdy_in),
    .inc_i (br_acc),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl against a behavioural reference model.
module tb_stall_ctrl;

  localparam int CW   = 8;
  localparam int AW   = 32;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          stallreq_if, stallreq_id, stallreq_mem, branch_req_ex, if_busy;
  logic [AW-1:0] branch_target_ex;
  logic [5:0]    stall_out;
  logic          branch_or_not, if_discard;
  logic [AW-1:0] branch_target;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: pending discard flag and plain integer counters.
  bit m_disc;
  int m_sc, m_fc;

  always #5 clk_in = ~clk_in;

  stall_ctrl #(.CNT_W(CW), .ADDR_W(AW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .stallreq_if      (stallreq_if),
    .stallreq_id      (stallreq_id),
    .stallreq_mem     (stallreq_mem),
    .branch_req_ex    (branch_req_ex),
    .branch_target_ex (branch_target_ex),
    .if_busy          (if_busy),
    .stall_out        (stall_out),
    .branch_or_not    (branch_or_not),
    .branch_target    (branch_target),
    .if_discard       (if_discard),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit f, input bit d, input bit m, input bit b,
                       input logic [31:0] t, input bit busy, input bit rdy);
    stallreq_if      = f;
    stallreq_id      = d;
    stallreq_mem     = m;
    branch_req_ex    = b;
    branch_target_ex = t;
    if_busy          = busy;
    rdy_in           = rdy;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Check all outputs mid-cycle, then advance one clock and update the model.
  task automatic step();
    logic [5:0]  e_stall;
    bit          acc;
    logic [31:0] e_tgt;
    #4;
    if (stallreq_mem)     e_stall = 6'b011111;
    else if (stallreq_id) e_stall = 6'b000111;
    else if (stallreq_if) e_stall = 6'b000011;
    else                  e_stall = 6'b000000;
    acc   = branch_req_ex && !stallreq_mem;
    e_tgt = acc ? branch_target_ex : 32'h0;
    chk("stall_out",     32'(stall_out),     32'(e_stall));
    chk("branch_or_not", 32'(branch_or_not), 32'(acc));
    chk("branch_target", branch_target,      e_tgt);
    chk("if_discard",    32'(if_discard),    32'(m_disc || (acc && if_busy)));
    chk("stall_cnt",     32'(stall_cnt),     m_sc);
    chk("flush_cnt",     32'(flush_cnt),     m_fc);
    @(posedge clk_in);
    if (rdy_in) begin
      if (e_stall != 0) m_sc = sat_inc(m_sc);
      if (acc)          m_fc = sat_inc(m_fc);
      // A discard is pending after any edge where a fetch is still busy and
      // either a discard was pending or a redirect was just accepted.
      m_disc = if_busy && (m_disc || acc);
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_in = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0, 1);
    m_disc = 0; m_sc = 0; m_fc = 0;
    #3;
    chk("rst_stall_out",  32'(stall_out),     32'h0);
    chk("rst_bon",        32'(branch_or_not), 32'h0);
    chk("rst_if_discard", 32'(if_discard),    32'h0);
    chk("rst_stall_cnt",  32'(stall_cnt),     32'h0);
    chk("rst_flush_cnt",  32'(flush_cnt),     32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // ID load-use only, then ID+MEM.
    drive(0, 1, 0, 0, 32'h0, 0, 1); steps(3);
    drive(0, 1, 1, 0, 32'h0, 0, 1); steps(2);
    drive(1, 0, 0, 0, 32'h0, 0, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 0, 1); steps(1);

    // Branch with idle fetch port.
    drive(0, 0, 0, 1, 32'h1000, 0, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 0, 1);    steps(1);

    // Branch held by MEM for 3 cycles, then accepted once.
    drive(0, 0, 1, 1, 32'h1234, 0, 1); steps(3);
    drive(0, 0, 0, 1, 32'h1234, 0, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 0, 1);    steps(1);

    // Branch with busy fetch; busy for 4 more cycles.
    drive(0, 0, 0, 1, 32'h3000, 1, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 1, 1);    steps(4);
    drive(0, 0, 0, 0, 32'h0, 0, 1);    steps(2);

    // Second branch mid-DISCARD.
    drive(0, 0, 0, 1, 32'h4000, 1, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 1, 1);    steps(1);
    drive(0, 0, 0, 1, 32'h2000, 1, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 1, 1);    steps(1);
    drive(0, 0, 0, 0, 32'h0, 0, 1);    steps(2);

    // rdy low during a stall and during a discard.
    drive(0, 1, 0, 0, 32'h0, 0, 0); steps(3);
    drive(0, 0, 0, 1, 32'h5000, 1, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 0, 0); steps(2);
    drive(0, 0, 0, 0, 32'h0, 0, 1); steps(1);

    // Reset pulse mid-DISCARD.
    drive(0, 0, 0, 1, 32'h6000, 1, 1); steps(1);
    drive(0, 0, 0, 0, 32'h0, 1, 1);    steps(1);
    #2 rst_in = 1'b1;
    #1;
    m_disc = 0; m_sc = 0; m_fc = 0;
    chk("rstmid_if_discard", 32'(if_discard), 32'h0);
    chk("rstmid_stall_cnt",  32'(stall_cnt),  32'h0);
    chk("rstmid_flush_cnt",  32'(flush_cnt),  32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    steps(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
            ($urandom % 3) == 0, $urandom, ($urandom % 2) == 0, ($urandom % 8) != 0);
      step();
    end

    // Drive both counters into saturation and hold there.
    drive(1, 0, 0, 1, 32'h7000, 0, 1); steps(CMAX + 5);
    chk("stall_cnt_sat", 32'(stall_cnt), CMAX);
    chk("flush_cnt_sat", 32'(flush_cnt), CMAX);
    drive(0, 0, 0, 0, 32'h0, 0, 1); steps(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
